// File: rtl/dbuf_arbiter.sv
// Round-robin arbiter with a registered command port in front of the shared 49152x32 data buffer.
// Optional hold-grant (client lock) support is compiled in with `define DBUF_ARB_LOCK_EN.
module dbuf_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 17,
    parameter int DEPTH = 49152,
    parameter int ECW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [ECW-1:0] err_cnt,
    output logic          m_rw,
    output logic [AW-1:0] m_didx,
    output logic [DW-1:0] m_din,
    input  logic [DW-1:0] m_di
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

`ifdef DBUF_ARB_LOCK_EN
    typedef enum logic [1:0] {ARB, HOLD0, HOLD1} state_e;
`else
    typedef enum logic {ARB} state_e;
`endif

    // Tag travelling alongside each accepted access until its return slot.
    typedef struct packed {
        logic vld;
        logic rd;
        logic id;
        logic oor;
    } tag_t;

    state_e         state_q, state_d;
    logic           ptr_q, ptr_d;
    logic           accept, sel;
    logic           sel_we, sel_oor;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;

    logic           m_rw_q, m_rw_d;
    logic [AW-1:0]  m_didx_q, m_didx_d;
    logic [DW-1:0]  m_din_q, m_din_d;
    tag_t           tag1_q, tag1_d, tag2_q, tag2_d;
    logic           rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic           err_q, err_d;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;
    logic [DW-1:0]  rdata_q, rdata_d;

`ifndef DBUF_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    // Grant outputs: ARB is plain round-robin, HOLDK admits only client K.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path infers a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state_q)
`ifdef DBUF_ARB_LOCK_EN
            HOLD0:   gnt0 = req0;
            HOLD1:   gnt1 = req1;
`endif
            default: begin
                gnt0 = req0 & (~req1 | ~ptr_q);
                gnt1 = req1 & (~req0 |  ptr_q);
            end
        endcase
    end

    always_comb begin
`ifdef DBUF_ARB_LOCK_EN
        state_d = state_q;
        case (state_q)
            ARB:     if (accept && (sel ? lock1 : lock0)) state_d = sel ? HOLD1 : HOLD0;
            HOLD0:   if (!req0 || !lock0) state_d = ARB;
            HOLD1:   if (!req1 || !lock1) state_d = ARB;
            default: state_d = ARB;
        endcase
`else
        state_d = ARB;
`endif
    end

    assign accept = gnt0 | gnt1;
    assign sel    = gnt1;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB) begin
            if (accept) ptr_d = ~sel;
        end
`ifdef DBUF_ARB_LOCK_EN
        else if (state_d == ARB) begin
            ptr_d = (state_q == HOLD0);
        end
`endif
    end

    always_comb begin
        sel_we    = sel ? we1    : we0;
        sel_addr  = sel ? addr1  : addr0;
        sel_wdata = sel ? wdata1 : wdata0;
        sel_oor   = (sel_addr > LAST_ADDR);

        m_rw_d   = accept & sel_we & ~sel_oor;
        m_didx_d = accept ? sel_addr  : m_didx_q;
        m_din_d  = accept ? sel_wdata : m_din_q;

        tag1_d.vld = accept;
        tag1_d.rd  = ~sel_we;
        tag1_d.id  = sel;
        tag1_d.oor = sel_oor;
        tag2_d     = tag1_q;

        rvalid0_d = tag2_q.vld & tag2_q.rd & ~tag2_q.id;
        rvalid1_d = tag2_q.vld & tag2_q.rd &  tag2_q.id;
        err_d     = tag2_q.vld & tag2_q.oor;

        rdata_d = rdata_q;
        if (rvalid0_d || rvalid1_d) rdata_d = tag2_q.oor ? '0 : m_di;

        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ECW'(1);
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            ptr_q     <= 1'b0;
            m_rw_q    <= 1'b0;
            m_didx_q  <= '0;
            m_din_q   <= '0;
            tag1_q    <= '0;
            tag2_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            m_rw_q    <= m_rw_d;
            m_didx_q  <= m_didx_d;
            m_din_q   <= m_din_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    assign m_rw    = m_rw_q;
    assign m_didx  = m_didx_q;
    assign m_din   = m_din_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_dbuf_arbiter.sv
// Bench for dbuf_arbiter: directed tables and sequences plus random traffic, all checked
// against a transaction-level model (favoured client, return queue, shadow memory).
module tb_dbuf_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 17;
    localparam int DEPTH = 49152;
    localparam int ECW   = 8;
    localparam int CMAX  = (1 << ECW) - 1;
    localparam logic [AW-1:0] OOR_BASE = AW'(DEPTH);

    logic           clk = 1'b0;
    logic           rst;
    logic           req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0]  addr0, addr1;
    logic [DW-1:0]  wdata0, wdata1;
    logic           gnt0, gnt1, rvalid0, rvalid1, err, m_rw;
    logic [DW-1:0]  rdata, m_din, m_di;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  m_didx;

    always #5 clk = ~clk;

    dbuf_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .ECW(ECW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err(err), .err_cnt(err_cnt),
        .m_rw(m_rw), .m_didx(m_didx), .m_din(m_din), .m_di(m_di)
    );

    // Behavioural single-port buffer: one-cycle read latency.
    // NOTE: buffer contents are never reset; a word not yet written reads as 0.
    logic [DW-1:0] mem [int];
    logic [DW-1:0] buf_rd;
    always @(posedge clk) begin
        buf_rd = mem.exists(int'(m_didx)) ? mem[int'(m_didx)] : '0;
        if (m_rw && (m_didx < OOR_BASE)) mem[int'(m_didx)] = m_din;
        m_di <= buf_rd;
    end

    typedef struct {
        bit            rst;
        bit            r0, w0, l0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        bit            r1, w1, l1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
    } stim_t;

    typedef struct {
        int            due;
        bit            id;
        bit            rd;
        bit            oor;
        logic [DW-1:0] data;
    } ret_t;

    typedef struct {
        stim_t         s;
        bit            g0, g1, rv0, rv1;
        logic [DW-1:0] rd;
    } vec_t;

    // Reference model state.
    ret_t          pend[$];
    logic [DW-1:0] shadow [int];
    int            fav, owner, cyc, exp_cnt;
    logic [AW-1:0] exp_didx;
    logic [DW-1:0] exp_din;
    logic          obs_g0, obs_g1;
    int            checks, errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, r0: 1'b0, w0: 1'b0, l0: 1'b0, a0: '0, d0: '0,
              r1: 1'b0, w1: 1'b0, l1: 1'b0, a1: '0, d1: '0};
        return s;
    endfunction

    function automatic stim_t rst_s();
        stim_t s = idle();
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t c0(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit l);
        stim_t s = idle();
        s.r0 = 1'b1; s.w0 = w; s.a0 = a; s.d0 = d; s.l0 = l;
        return s;
    endfunction

    function automatic stim_t c1(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit l);
        stim_t s = idle();
        s.r1 = 1'b1; s.w1 = w; s.a1 = a; s.d1 = d; s.l1 = l;
        return s;
    endfunction

    function automatic stim_t both(input stim_t x, input stim_t y);
        stim_t s = x;
        s.r1 = y.r1; s.w1 = y.w1; s.a1 = y.a1; s.d1 = y.d1; s.l1 = y.l1;
        return s;
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        int p = $urandom_range(99);
        if (p < 70) return AW'($urandom_range(63));
        if (p < 85) return AW'($urandom_range(DEPTH - 1));
        return AW'($urandom_range(131071, DEPTH));
    endfunction

    // One clock: drive, check grants mid-cycle, then check registered outputs after the edge.
    task automatic step(input stim_t s);
        logic          g0, g1, win, we, oor, e_rw, e_rv0, e_rv1, e_err;
        logic [AW-1:0] a;
        logic [DW-1:0] d, e_rdata;
        int            prev_owner;
        ret_t          r;
        rst = s.rst;
        req0 = s.r0; we0 = s.w0; addr0 = s.a0; wdata0 = s.d0; lock0 = s.l0;
        req1 = s.r1; we1 = s.w1; addr1 = s.a1; wdata1 = s.d1; lock1 = s.l1;
        @(negedge clk);
        if (owner == 0) begin
            g0 = s.r0; g1 = 1'b0;
        end else if (owner == 1) begin
            g0 = 1'b0; g1 = s.r1;
        end else if (s.r0 && s.r1) begin
            g0 = (fav == 0); g1 = (fav == 1);
        end else begin
            g0 = s.r0; g1 = s.r1;
        end
        obs_g0 = gnt0;
        obs_g1 = gnt1;
        check("gnt0", 32'(gnt0), 32'(g0));
        check("gnt1", 32'(gnt1), 32'(g1));
        @(posedge clk);
        #1;
        cyc++;
        prev_owner = owner;
        e_rw = 1'b0;
        if (s.rst) begin
            fav = 0; owner = -1; exp_cnt = 0;
            exp_didx = '0; exp_din = '0;
            pend.delete();
        end else if (g0 || g1) begin
            win = g1;
            we  = win ? s.w1 : s.w0;
            a   = win ? s.a1 : s.a0;
            d   = win ? s.d1 : s.d0;
            oor = (a >= OOR_BASE);
            e_rw = we && !oor;
            exp_didx = a;
            exp_din  = d;
            r = '{cyc + 2, win, !we, oor, (we || oor) ? '0 : shadow_rd(a)};
            pend.push_back(r);
            if (e_rw) shadow[int'(a)] = d;
            if (prev_owner < 0) begin
                fav = win ? 0 : 1;
`ifdef DBUF_ARB_LOCK_EN
                if (win ? s.l1 : s.l0) owner = win ? 1 : 0;
`endif
            end
        end
`ifdef DBUF_ARB_LOCK_EN
        if (!s.rst && prev_owner >= 0) begin
            if (!(prev_owner == 1 ? s.r1 : s.r0) || !(prev_owner == 1 ? s.l1 : s.l0)) begin
                fav = 1 - prev_owner;
                owner = -1;
            end
        end
`endif
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_err = 1'b0; e_rdata = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (r.oor) begin
                e_err = 1'b1;
                if (exp_cnt < CMAX) exp_cnt++;
            end
            if (r.rd) begin
                if (r.id) e_rv1 = 1'b1;
                else      e_rv0 = 1'b1;
                e_rdata = r.data;
            end
        end
        check("rvalid0", 32'(rvalid0), 32'(e_rv0));
        check("rvalid1", 32'(rvalid1), 32'(e_rv1));
        check("err", 32'(err), 32'(e_err));
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
        check("m_rw", 32'(m_rw), 32'(e_rw));
        check("m_didx", 32'(m_didx), 32'(exp_didx));
        check("m_din", 32'(m_din), 32'(exp_din));
        if (e_rv0 || e_rv1) check("rdata", rdata, e_rdata);
    endtask

    vec_t  tbl [8];
    bit    lock_g1 [6];
    stim_t rs;

    initial begin
        checks = 0; errors = 0;
        fav = 0; owner = -1; cyc = 0; exp_cnt = 0;
        exp_didx = '0; exp_din = '0;
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; lock0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;

        // Simultaneous reads of 0x10 / 0x20: grants alternate, returns follow two cycles later.
        tbl[0] = '{both(c0(0, 17'h10, 0, 0), c1(0, 17'h20, 0, 0)), 1, 0, 0, 0, 32'd0};
        tbl[1] = '{both(c0(0, 17'h10, 0, 0), c1(0, 17'h20, 0, 0)), 0, 1, 0, 0, 32'd0};
        tbl[2] = '{both(c0(0, 17'h10, 0, 0), c1(0, 17'h20, 0, 0)), 1, 0, 1, 0, 32'd1};
        tbl[3] = '{both(c0(0, 17'h10, 0, 0), c1(0, 17'h20, 0, 0)), 0, 1, 0, 1, 32'd2};
        tbl[4] = '{both(c0(0, 17'h10, 0, 0), c1(0, 17'h20, 0, 0)), 1, 0, 1, 0, 32'd1};
        tbl[5] = '{both(c0(0, 17'h10, 0, 0), c1(0, 17'h20, 0, 0)), 0, 1, 0, 1, 32'd2};
        tbl[6] = '{idle(), 0, 0, 1, 0, 32'd1};
        tbl[7] = '{idle(), 0, 0, 0, 1, 32'd2};
`ifdef DBUF_ARB_LOCK_EN
        lock_g1 = '{0, 0, 0, 0, 0, 1};
`else
        lock_g1 = '{0, 1, 0, 1, 0, 1};
`endif

        repeat (3) @(posedge clk);
        #1;
        step(rst_s());

        // Write then read, client 0.
        step(c0(1, 17'd5, 32'hDEADBEEF, 0));
        check("wr_m_rw", 32'(m_rw), 32'd1);
        check("wr_m_didx", 32'(m_didx), 32'd5);
        step(c0(0, 17'd5, 0, 0));
        step(idle());
        step(idle());
        check("rd_rvalid0", 32'(rvalid0), 32'd1);
        check("rd_rdata", rdata, 32'hDEADBEEF);
        check("rd_rvalid1", 32'(rvalid1), 32'd0);

        // Simultaneous requests.
        step(rst_s());
        step(c0(1, 17'h10, 32'd1, 0));
        step(c1(1, 17'h20, 32'd2, 0));
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s);
            check("tbl_gnt0", 32'(obs_g0), 32'(tbl[i].g0));
            check("tbl_gnt1", 32'(obs_g1), 32'(tbl[i].g1));
            check("tbl_rvalid0", 32'(rvalid0), 32'(tbl[i].rv0));
            check("tbl_rvalid1", 32'(rvalid1), 32'(tbl[i].rv1));
            if (tbl[i].rv0 || tbl[i].rv1) check("tbl_rdata", rdata, tbl[i].rd);
        end

        // Out of range write next to the last valid word.
        step(rst_s());
        step(c1(1, 17'd49151, 32'hA5A50F0F, 0));
        step(c1(1, 17'd49152, 32'd7, 0));
        check("oor_m_rw", 32'(m_rw), 32'd0);
        step(c1(0, 17'd49151, 0, 0));
        check("oor_rd_m_rw", 32'(m_rw), 32'd0);
        step(idle());
        check("oor_err", 32'(err), 32'd1);
        check("oor_err_cnt", 32'(err_cnt), 32'd1);
        step(idle());
        check("last_err", 32'(err), 32'd0);
        check("last_rvalid1", 32'(rvalid1), 32'd1);
        check("last_rdata", rdata, 32'hA5A50F0F);
        check("last_err_cnt", 32'(err_cnt), 32'd1);

        // Reset while a read is in flight.
        step(c0(0, 17'd5, 0, 0));
        step(rst_s());
        check("rst_m_didx", 32'(m_didx), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        step(idle());
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        step(both(c0(0, 17'd1, 0, 0), c1(0, 17'd2, 0, 0)));
        check("rst_first_gnt0", 32'(obs_g0), 32'd1);
        check("rst_first_gnt1", 32'(obs_g1), 32'd0);

        // Error counter saturation.
        step(rst_s());
        for (int i = 0; i < 300; i++) step(c0(i[0], OOR_BASE + AW'(i), 32'(i), 0));
        step(idle());
        step(idle());
        check("sat_cnt", 32'(err_cnt), 32'd255);
        for (int i = 0; i < 20; i++) step(c1(i[0], 17'h1FFFF - AW'(i), 0, 0));
        step(idle());
        step(idle());
        check("sat_hold", 32'(err_cnt), 32'd255);

        // Client 0 lock with client 1 requesting throughout.
        step(rst_s());
        for (int i = 0; i < 6; i++) begin
            step(both(c0(0, AW'(i), 0, i < 4), c1(0, 17'd9, 0, 0)));
            check("lock_gnt1", 32'(obs_g1), 32'(lock_g1[i]));
        end
        step(idle());
        step(idle());

        // Random traffic against the model.
        for (int i = 0; i < 1200; i++) begin
            rs = idle();
            rs.rst = ($urandom_range(99) == 0);
            rs.r0 = ($urandom_range(3) != 0);
            rs.w0 = $urandom_range(1) == 1;
            rs.a0 = rand_addr();
            rs.d0 = $urandom;
            rs.l0 = $urandom_range(1) == 1;
            rs.r1 = ($urandom_range(3) != 0);
            rs.w1 = $urandom_range(1) == 1;
            rs.a1 = rand_addr();
            rs.d1 = $urandom;
            rs.l1 = $urandom_range(1) == 1;
            step(rs);
        end
        repeat (3) step(idle());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbuf_arbiter.md
Name: dbuf_arbiter

Overview:
- Shares the single-port 49152x32 data buffer between two requesters: client 0 (loader/DMA side) and client 1 (PDM compute side).
- Arbitrates round-robin per access, registers the winning command onto the buffer port, and routes returned read data back to the issuing client.
- Range-checks every address and counts rejected accesses.
- Sits directly in front of the buffer; the buffer's ports are driven only by this block.

Parameters:
- DW, 32, data width.
- AW, 17, address width.
- DEPTH, 49152, number of valid words; valid addresses are 0..DEPTH-1.
- ECW, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  client request.
- we0 / we1  in  1  1 = write, 0 = read; sampled with req.
- addr0 / addr1  in  AW  word address.
- wdata0 / wdata1  in  DW  write data.
- lock0 / lock1  in  1  hold-grant request; used only with DBUF_ARB_LOCK_EN.
- gnt0 / gnt1  out  1  combinational grant; req&gnt at a rising edge = accepted.
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse.
- rdata  out  DW  read data, shared by both clients, qualified by rvalid0/rvalid1.
- err  out  1  one-cycle pulse: out-of-range access accepted 2 cycles earlier.
- err_cnt  out  ECW  saturating count of out-of-range accesses.
- m_rw  out  1  buffer write enable.
- m_didx  out  AW  buffer address.
- m_din  out  DW  buffer write data.
- m_di  in  DW  buffer read data, valid the cycle after the buffer samples m_didx.

Behaviour:
- Reset (synchronous, active-high), values at the first edge with rst=1:
  - m_rw=0, m_didx=0, m_din=0.
  - rvalid0=rvalid1=0, err=0, err_cnt=0.
  - Round-robin pointer favours client 0.
  - FSM goes to ARB.
- Reset mid-operation: in-flight reads are discarded; no rvalid for them after reset.
- Grant (combinational, from req0/req1, the registered pointer and the FSM state):
  - Only one requester active: that requester wins.
  - Both active: the pointer-favoured client wins.
  - At most one gnt is high; gnt is never high without its req.
  - After each accepted access the pointer favours the other client.
- Pipeline, for an access accepted at edge N:
  - Edge N: command register loads m_didx=addr and m_din=wdata. m_rw is loaded as we AND in-range.
  - Edge N+1: the buffer executes the access.
  - Edge N+2: read return registers. rdata=m_di and the client's rvalid=1 for one cycle.
- Throughput: one access per cycle sustained; no bubbles between back-to-back grants.
- Write data is not echoed: writes never produce rvalid.
- No accepted access: m_rw is registered 0. m_didx and m_din hold their previous values.
- Range check: addr >= DEPTH (49152..131071) is out of range.
  - Out-of-range write: accepted, m_rw forced 0, memory untouched.
  - Out-of-range read: accepted; rvalid still pulses at N+2 with rdata=0.
  - In both cases err pulses at N+2.
  - err_cnt increments at N+2 and saturates at 2^ECW-1.
- Read tag: a 2-stage shift register carries {valid, client id, out-of-range} alongside each access and selects the rvalid/err/rdata-zero behaviour.
- FSM states:
  - ARB: normal round-robin arbitration.
  - HOLD0 / HOLD1: exist only with DBUF_ARB_LOCK_EN.
  - Without the macro the FSM stays in ARB permanently.

Optional Feature:
- Macro: DBUF_ARB_LOCK_EN.
- Defined:
  - A grant accepted with lockK=1 moves the FSM ARB->HOLDK.
  - In HOLDK only client K can be granted, even if the other client is requesting. The pointer is not updated.
  - HOLDK returns to ARB on an accepted access with lockK=0, or on any cycle with reqK=0.
  - After leaving HOLDK the pointer favours the other client.
  - rst forces ARB.
- Undefined:
  - lock0/lock1 are ignored (inputs present, unused).
  - No HOLD states are synthesized.

Test Plan:
- Write then read, client 0:
  - Stimulus: write addr 5 data 32'hDEADBEEF, then read addr 5 on the next cycle.
  - Required: m_rw=1 one cycle after the write grant; rvalid0 two cycles after the read grant with rdata=32'hDEADBEEF; rvalid1 stays 0.
- Simultaneous requests:
  - Stimulus: req0 and req1 both held high for 6 cycles, reads of addr 0x10 and 0x20 preloaded with 1 and 2.
  - Required: grants alternate 0,1,0,1,0,1; rvalid0 (rdata=1) and rvalid1 (rdata=2) alternate, starting 2 cycles after the first grant.
- Out of range:
  - Stimulus: client 1 writes addr 49152 data 7, then reads addr 49151.
  - Required: m_rw stays 0; err pulses once and err_cnt=1; the read of addr 49151 returns that word's prior content and does not assert err.
- Reset mid-flight:
  - Stimulus: read accepted at edge N, rst=1 at edge N+1.
  - Required: no rvalid at N+2; all outputs at their reset values; the first grant after reset goes to client 0 when both clients request.
- Saturation:
  - Stimulus: 300 out-of-range accesses with ECW=8.
  - Required: err_cnt=255 and stays 255.
- Lock, with DBUF_ARB_LOCK_EN:
  - Stimulus: client 0 issues 4 accesses with lock0=1, then one with lock0=0, while req1 is high throughout.
  - Required: gnt1=0 for all 5 client-0 accesses; gnt1=1 on the next cycle.
  - Without the macro: the same stimulus produces alternating grants.
